// File: rtl/alu_issue_ctrl.sv
// ---------------------------------------------------------------------------
// alu_issue_ctrl
//
// Issues one 4-bit operand pair to an external combinational ALU once per
// enabled operation and gathers the four 4-bit results into a single bundle.
//
// Ops are issued one per clock in ascending index order (0 add, 1 sub,
// 2 AND, 3 OR). Only ops whose bit is set in OP_MASK are issued. The slots
// of disabled ops read zero.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | ready for a command; alu_cont parked at 00, operands retained
// RUN   | one enabled op per cycle; alu_out captured into its slot
// HOLD  | bundle presented with res_valid until res_ready is seen
//
// Ports
//   clk        : single clock, all state updates on the rising edge
//   rst        : asynchronous active-high reset
//   cmd_valid  : command present
//   cmd_ready  : controller can accept a command (high only in IDLE)
//   cmd_a/b    : 4-bit operands, latched on accept
//   alu_a/b    : latched operands driven to the ALU
//   alu_cont   : ALU op select (00 add, 01 sub, 10 AND, 11 OR)
//   alu_out    : combinational ALU result
//   res_valid  : result bundle available (high only in HOLD)
//   res_ready  : consumer accepts the bundle
//   res_data   : [3:0] add, [7:4] sub, [11:8] AND, [15:12] OR
//   busy       : high whenever the controller is not IDLE
//
// Every output is either a flop or a decode of flops only, so there is no
// combinational path from cmd_* or res_ready to any output.
// ---------------------------------------------------------------------------
module alu_issue_ctrl #(
    parameter logic [3:0] OP_MASK = 4'b1111
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [3:0]  cmd_a,
    input  logic [3:0]  cmd_b,
    output logic [3:0]  alu_a,
    output logic [3:0]  alu_b,
    output logic [1:0]  alu_cont,
    input  logic [3:0]  alu_out,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [15:0] res_data,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } state_t;

    // Lowest enabled op index; 0 when nothing is enabled.
    function automatic logic [1:0] first_enabled_op();
        logic [1:0] r;
        r = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (OP_MASK[i]) begin
                r = 2'(i);
            end
        end
        return r;
    endfunction

    // Highest enabled op index; the op whose capture ends RUN.
    function automatic logic [1:0] last_enabled_op();
        logic [1:0] r;
        r = 2'd0;
        for (int i = 0; i <= 3; i++) begin
            if (OP_MASK[i]) begin
                r = 2'(i);
            end
        end
        return r;
    endfunction

    // Smallest enabled op above cur. Only called while cur is below the last
    // enabled op, so a successor always exists and the counter never wraps.
    function automatic logic [1:0] next_enabled_op(input logic [1:0] cur);
        logic [1:0] r;
        r = cur;
        for (int i = 3; i >= 0; i--) begin
            if (OP_MASK[i] && (i > int'(cur))) begin
                r = 2'(i);
            end
        end
        return r;
    endfunction

    localparam logic [1:0] FIRST_OP = first_enabled_op();
    localparam logic [1:0] LAST_OP  = last_enabled_op();
    localparam bit         NO_OPS   = (OP_MASK == 4'b0000);

    state_t      state_q,    state_d;
    logic [1:0]  op_q,       op_d;
    logic [3:0]  alu_a_q,    alu_a_d;
    logic [3:0]  alu_b_q,    alu_b_d;
    logic [15:0] res_data_q, res_data_d;

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        alu_a_d    = alu_a_q;
        alu_b_d    = alu_b_q;
        res_data_d = res_data_q;

        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    alu_a_d    = cmd_a;
                    alu_b_d    = cmd_b;
                    res_data_d = 16'h0000;
                    op_d       = FIRST_OP;
                    // With no enabled ops the empty bundle is ready at once.
                    state_d    = NO_OPS ? HOLD : RUN;
                end
            end

            RUN: begin
                case (op_q)
                    2'd0:    res_data_d[3:0]   = alu_out;
                    2'd1:    res_data_d[7:4]   = alu_out;
                    2'd2:    res_data_d[11:8]  = alu_out;
                    default: res_data_d[15:12] = alu_out;
                endcase
                if (op_q == LAST_OP) begin
                    state_d = HOLD;
                end else begin
                    op_d = next_enabled_op(op_q);
                end
            end

            HOLD: begin
                if (res_ready) begin
                    state_d = IDLE;
                    op_d    = 2'd0;
                end
            end

            default: begin
                state_d = IDLE;
                op_d    = 2'd0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            op_q       <= 2'd0;
            alu_a_q    <= 4'd0;
            alu_b_q    <= 4'd0;
            res_data_q <= 16'h0000;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            alu_a_q    <= alu_a_d;
            alu_b_q    <= alu_b_d;
            res_data_q <= res_data_d;
        end
    end

    // Decodes of registered state only.
    assign cmd_ready = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign res_valid = (state_q == HOLD);
    assign alu_cont  = (state_q == RUN) ? op_q : 2'b00;
    assign alu_a     = alu_a_q;
    assign alu_b     = alu_b_q;
    assign res_data  = res_data_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// ---------------------------------------------------------------------------
// tb_alu_issue_ctrl
//
// Three controllers (OP_MASK 1111, 0101, 0000) share one command/response
// stream, each with its own ALU model on alu_out. A transaction-level model
// per instance (operands, number of ops captured so far, active flag)
// predicts every output each cycle; directed literal checks pin the model.
// ---------------------------------------------------------------------------
module tb_alu_issue_ctrl;

    localparam int NI = 3;
    localparam logic [3:0] MASKS [NI] = '{4'b1111, 4'b0101, 4'b0000};

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       cmd_valid = 1'b0;
    logic       res_ready = 1'b0;
    logic [3:0] cmd_a = 4'd0;
    logic [3:0] cmd_b = 4'd0;

    logic        cmd_ready_w [NI];
    logic        res_valid_w [NI];
    logic        busy_w      [NI];
    logic [3:0]  alu_a_w     [NI];
    logic [3:0]  alu_b_w     [NI];
    logic [3:0]  alu_out_w   [NI];
    logic [1:0]  alu_cont_w  [NI];
    logic [15:0] res_data_w  [NI];

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    function automatic logic [3:0] alu_f(input logic [3:0] a, input logic [3:0] b,
                                         input logic [1:0] op);
        case (op)
            2'd0:    return a + b;
            2'd1:    return a - b;
            2'd2:    return a & b;
            default: return a | b;
        endcase
    endfunction

    for (genvar g = 0; g < NI; g++) begin : g_dut
        alu_issue_ctrl #(.OP_MASK(MASKS[g])) u_dut (
            .clk       (clk),
            .rst       (rst),
            .cmd_valid (cmd_valid),
            .cmd_ready (cmd_ready_w[g]),
            .cmd_a     (cmd_a),
            .cmd_b     (cmd_b),
            .alu_a     (alu_a_w[g]),
            .alu_b     (alu_b_w[g]),
            .alu_cont  (alu_cont_w[g]),
            .alu_out   (alu_out_w[g]),
            .res_valid (res_valid_w[g]),
            .res_ready (res_ready),
            .res_data  (res_data_w[g]),
            .busy      (busy_w[g])
        );
        assign alu_out_w[g] = alu_f(alu_a_w[g], alu_b_w[g], alu_cont_w[g]);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // k-th enabled op (ascending) for a mask.
    function automatic logic [1:0] op_at(input logic [3:0] m, input int k);
        int cnt = 0;
        for (int op = 0; op < 4; op++) begin
            if (m[op]) begin
                if (cnt == k) return 2'(op);
                cnt++;
            end
        end
        return 2'd0;
    endfunction

    // Bundle with the first k enabled ops filled in.
    function automatic logic [15:0] bundle(input logic [3:0] a, input logic [3:0] b,
                                           input logic [3:0] m, input int k);
        logic [15:0] r = 16'h0000;
        int cnt = 0;
        for (int op = 0; op < 4; op++) begin
            if (m[op]) begin
                if (cnt < k) r[4*op +: 4] = alu_f(a, b, 2'(op));
                cnt++;
            end
        end
        return r;
    endfunction

    bit          m_act [NI];
    int          m_k   [NI];
    logic [3:0]  m_a   [NI];
    logic [3:0]  m_b   [NI];
    logic [15:0] m_res [NI];

    bit b2b_phase   = 1'b0;
    bit prev_ready0 = 1'b0;
    int cyc         = 0;
    int last_acc    = -1;
    int n_gaps      = 0;

    initial begin
        bit         s_rst, s_cv, s_rr;
        logic [3:0] s_a, s_b;
        int         n;
        for (int i = 0; i < NI; i++) begin
            m_act[i] = 1'b0; m_k[i] = 0; m_a[i] = 4'd0; m_b[i] = 4'd0; m_res[i] = 16'h0;
        end
        forever begin
            @(posedge clk);
            s_rst = rst; s_cv = cmd_valid; s_rr = res_ready; s_a = cmd_a; s_b = cmd_b;

            if (b2b_phase && prev_ready0 && s_cv) begin
                if (last_acc >= 0) begin
                    chk("b2b_gap", 32'(cyc - last_acc), 32'($countones(MASKS[0]) + 2));
                    n_gaps++;
                end
                last_acc = cyc;
            end

            for (int i = 0; i < NI; i++) begin
                n = $countones(MASKS[i]);
                if (s_rst) begin
                    m_act[i] = 1'b0; m_k[i] = 0; m_a[i] = 4'd0; m_b[i] = 4'd0; m_res[i] = 16'h0;
                end else if (!m_act[i]) begin
                    if (s_cv) begin
                        m_act[i] = 1'b1; m_k[i] = 0; m_a[i] = s_a; m_b[i] = s_b; m_res[i] = 16'h0;
                    end
                end else if (m_k[i] < n) begin
                    m_k[i]++;
                    m_res[i] = bundle(m_a[i], m_b[i], MASKS[i], m_k[i]);
                end else if (s_rr) begin
                    m_act[i] = 1'b0;
                end
            end

            #1;
            for (int i = 0; i < NI; i++) begin
                bit holding, running;
                n = $countones(MASKS[i]);
                holding = m_act[i] && (m_k[i] == n);
                running = m_act[i] && (m_k[i] < n);
                chk($sformatf("u%0d_cmd_ready", i), 32'(cmd_ready_w[i]), 32'(!m_act[i]));
                chk($sformatf("u%0d_busy", i),      32'(busy_w[i]),      32'(m_act[i]));
                chk($sformatf("u%0d_res_valid", i), 32'(res_valid_w[i]), 32'(holding));
                chk($sformatf("u%0d_res_data", i),  32'(res_data_w[i]),  32'(m_res[i]));
                chk($sformatf("u%0d_alu_a", i),     32'(alu_a_w[i]),     32'(m_a[i]));
                chk($sformatf("u%0d_alu_b", i),     32'(alu_b_w[i]),     32'(m_b[i]));
                if (!holding)
                    chk($sformatf("u%0d_alu_cont", i), 32'(alu_cont_w[i]),
                        running ? 32'(op_at(MASKS[i], m_k[i])) : 32'd0);
            end
            prev_ready0 = cmd_ready_w[0];
            cyc++;
        end
    end

    // ---------------- directed helpers ----------------
    task automatic reset_vals_chk(input int i, input string tag);
        chk($sformatf("%s_u%0d_cmd_ready", tag, i), 32'(cmd_ready_w[i]), 32'd1);
        chk($sformatf("%s_u%0d_res_valid", tag, i), 32'(res_valid_w[i]), 32'd0);
        chk($sformatf("%s_u%0d_busy", tag, i),      32'(busy_w[i]),      32'd0);
        chk($sformatf("%s_u%0d_res_data", tag, i),  32'(res_data_w[i]),  32'd0);
        chk($sformatf("%s_u%0d_alu_a", tag, i),     32'(alu_a_w[i]),     32'd0);
        chk($sformatf("%s_u%0d_alu_b", tag, i),     32'(alu_b_w[i]),     32'd0);
        chk($sformatf("%s_u%0d_alu_cont", tag, i),  32'(alu_cont_w[i]),  32'd0);
    endtask

    task automatic wait_valid(input int i, input int budget);
        for (int t = 0; t < budget; t++) begin
            if (res_valid_w[i]) return;
            @(posedge clk);
            #2;
        end
        checks++;
        failures++;
        $display("FAIL wait_res_valid_u%0d actual=timeout required=res_valid within %0d cycles", i, budget);
    endtask

    // One command on idle controllers with res_ready high; checks the full bundle.
    task automatic run_cmd(input logic [3:0] a, input logic [3:0] b, input logic [15:0] exp,
                           input string name);
        @(negedge clk);
        cmd_valid = 1'b1; cmd_a = a; cmd_b = b; res_ready = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        wait_valid(0, 10);
        chk(name, 32'(res_data_w[0]), 32'(exp));
        repeat (3) @(negedge clk);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        #1 rst = 1'b1;
        #1;
        for (int i = 0; i < NI; i++) reset_vals_chk(i, "por");
        @(negedge clk);
        rst = 1'b0;

        // A=5 B=3, full mask: alu_cont 00,01,10,11 then res_valid at E4.
        @(negedge clk);
        cmd_valid = 1'b1; cmd_a = 4'h5; cmd_b = 4'h3; res_ready = 1'b1;
        @(posedge clk); #2;
        chk("lat_e0_cont", 32'(alu_cont_w[0]), 32'd0);
        chk("lat_e0_ready", 32'(cmd_ready_w[0]), 32'd0);
        @(negedge clk);
        cmd_valid = 1'b0;
        for (int t = 1; t <= 3; t++) begin
            @(posedge clk); #2;
            chk($sformatf("lat_e%0d_cont", t), 32'(alu_cont_w[0]), 32'(t));
            chk($sformatf("lat_e%0d_valid", t), 32'(res_valid_w[0]), 32'd0);
        end
        @(posedge clk); #2;
        chk("lat_e4_valid", 32'(res_valid_w[0]), 32'd1);
        chk("lat_e4_data", 32'(res_data_w[0]), 32'h7128);
        repeat (3) @(negedge clk);

        run_cmd(4'h3, 4'h5, 16'h71E8, "sub_wrap_data");
        run_cmd(4'hF, 4'h1, 16'hF1E0, "add_wrap_data");

        // Sparse mask 0101 with A=C B=A; empty mask finishes immediately.
        @(negedge clk);
        cmd_valid = 1'b1; cmd_a = 4'hC; cmd_b = 4'hA; res_ready = 1'b1;
        @(posedge clk); #2;
        chk("sparse_cont0", 32'(alu_cont_w[1]), 32'd0);
        chk("zero_valid", 32'(res_valid_w[2]), 32'd1);
        chk("zero_data", 32'(res_data_w[2]), 32'h0000);
        @(negedge clk);
        cmd_valid = 1'b0;
        @(posedge clk); #2;
        chk("sparse_cont1", 32'(alu_cont_w[1]), 32'd2);
        @(posedge clk); #2;
        chk("sparse_valid", 32'(res_valid_w[1]), 32'd1);
        chk("sparse_data", 32'(res_data_w[1]), 32'h0806);
        repeat (4) @(negedge clk);

        // Back-pressure: res_ready low for 10 cycles in HOLD with cmd_valid high.
        @(negedge clk);
        res_ready = 1'b0; cmd_valid = 1'b1; cmd_a = 4'h5; cmd_b = 4'h3;
        wait_valid(0, 10);
        for (int t = 0; t < 10; t++) begin
            @(posedge clk); #2;
            chk("hold_data", 32'(res_data_w[0]), 32'h7128);
            chk("hold_ready", 32'(cmd_ready_w[0]), 32'd0);
        end
        @(negedge clk);
        res_ready = 1'b1; cmd_valid = 1'b0;
        @(posedge clk); #2;
        chk("release_valid", 32'(res_valid_w[0]), 32'd0);
        @(posedge clk); #2;
        chk("release_idle", 32'(busy_w[0]), 32'd0);
        repeat (3) @(negedge clk);

        // Reset after two ops have been captured.
        @(negedge clk);
        cmd_valid = 1'b1; cmd_a = 4'h5; cmd_b = 4'h3; res_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        reset_vals_chk(0, "midrun");
        reset_vals_chk(1, "midrun");
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        run_cmd(4'h5, 4'h3, 16'h7128, "after_rst_data");

        // Back-to-back with cmd_valid held.
        @(negedge clk);
        b2b_phase = 1'b1; last_acc = -1; n_gaps = 0;
        cmd_valid = 1'b1; cmd_a = 4'h9; cmd_b = 4'h6; res_ready = 1'b1;
        repeat (30) @(negedge clk);
        cmd_valid = 1'b0;
        b2b_phase = 1'b0;
        chk("b2b_gap_count", 32'(n_gaps >= 3), 32'd1);
        repeat (8) @(negedge clk);

        // Randomized traffic, with occasional resets.
        repeat (1500) begin
            @(negedge clk);
            cmd_valid = 1'($urandom_range(0, 1));
            cmd_a     = 4'($urandom);
            cmd_b     = 4'($urandom);
            res_ready = ($urandom_range(0, 3) != 0);
            rst       = ($urandom_range(0, 99) == 0);
        end
        @(negedge clk);
        rst = 1'b0; cmd_valid = 1'b0; res_ready = 1'b1;
        repeat (10) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
